// File: rtl/scroll_engine.sv
// scroll_engine
//   Executes line-scroll requests against the text-cell RAM, one cell per
//   clock. A request moves lines [top,bottom] up or down by N lines and
//   fills the vacated lines with BLANK. One request can wait in a pending
//   slot while another is running. A request that arrives while the slot is
//   already occupied is dropped and sets a sticky overflow flag.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   i_req_valid         one-cycle request strobe
//   i_req_dir           0 = up (content toward top), 1 = down
//   i_req_step          lines to scroll (N)
//   i_req_top/_bottom   inclusive absolute line range
//   o_busy              request in progress (COPY..DONE)
//   o_done              one-cycle completion pulse (no-ops included)
//   o_overflow          sticky: a request was dropped
//   o_rd_en/o_rd_addr   RAM read; i_rd_data returns the next cycle
//   o_wr_en/o_wr_addr/o_wr_data  RAM write
module scroll_engine #(
  parameter int                 COLUMNS = 80,
  parameter int                 LINES   = 25,
  parameter int                 ADDR_W  = 12,
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  BLANK   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic              i_req_dir,
  input  logic [7:0]        i_req_step,
  input  logic [7:0]        i_req_top,
  input  logic [7:0]        i_req_bottom,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLUMNS - 1);

  typedef enum logic [2:0] {S_IDLE, S_COPY, S_DRAIN, S_BLANK, S_DONE} state_t;

  state_t             r_state, w_state_n;
  logic               r_dir, w_dir_n;
  logic [7:0]         r_n, w_n_n;
  logic [7:0]         r_top, w_top_n;
  logic [7:0]         r_bottom, w_bot_n;
  logic [7:0]         r_line, w_line_n;   // current destination line
  logic [COL_W-1:0]   r_col, w_col_n;
  logic [7:0]         r_left, w_left_n;   // lines remaining in this phase

  // copy-write stage: address of the cell read last cycle
  logic               r_cw_vld;
  logic [ADDR_W-1:0]  r_cw_addr;

  // pending slot
  logic               r_pend_vld;
  logic               r_pend_dir;
  logic [7:0]         r_pend_step, r_pend_top, r_pend_bot;
  logic               r_overflow;

  // request source: the pending slot has priority when leaving DONE
  logic               w_start, w_from_pend;
  logic               w_s_dir;
  logic [7:0]         w_s_step, w_s_top, w_s_bot;
  logic               w_noop;
  logic [7:0]         w_r, w_n, w_copy, w_s_bl0, w_reg_bl0;
  logic [7:0]         w_src_line;
  logic [ADDR_W-1:0]  w_dst_addr, w_src_addr;
  logic               w_in_blank;

  assign w_from_pend = (r_state == S_DONE) && r_pend_vld;
  assign w_start     = ((r_state == S_IDLE) && i_req_valid) ||
                       ((r_state == S_DONE) && (r_pend_vld || i_req_valid));

  assign w_s_dir  = w_from_pend ? r_pend_dir  : i_req_dir;
  assign w_s_step = w_from_pend ? r_pend_step : i_req_step;
  assign w_s_top  = w_from_pend ? r_pend_top  : i_req_top;
  assign w_s_bot  = w_from_pend ? r_pend_bot  : i_req_bottom;

  assign w_noop = (w_s_step == 8'd0) || (w_s_top > w_s_bot) ||
                  (w_s_bot >= 8'(LINES));
  assign w_r    = w_s_bot - w_s_top + 8'd1;
  assign w_n    = (w_s_step < w_r) ? w_s_step : w_r;
  assign w_copy = w_r - w_n;

  // first vacated line; blanking always runs upward from here for n lines
  assign w_s_bl0   = w_s_dir ? w_s_top : (w_s_bot - w_n + 8'd1);
  assign w_reg_bl0 = r_dir   ? r_top   : (r_bottom - r_n + 8'd1);

  // source lies n lines below the destination for up, above it for down
  assign w_src_line = r_dir ? (r_line - r_n) : (r_line + r_n);
  assign w_dst_addr = ADDR_W'(r_line) * ADDR_W'(COLUMNS) + ADDR_W'(r_col);
  assign w_src_addr = ADDR_W'(w_src_line) * ADDR_W'(COLUMNS) + ADDR_W'(r_col);

  // next-state and traversal
  always_comb begin
    w_state_n = r_state;
    w_dir_n   = r_dir;
    w_n_n     = r_n;
    w_top_n   = r_top;
    w_bot_n   = r_bottom;
    w_line_n  = r_line;
    w_col_n   = r_col;
    w_left_n  = r_left;
    case (r_state)
      S_COPY: begin
        if (r_col == COL_LAST) begin
          w_col_n  = '0;
          w_left_n = r_left - 8'd1;
          w_line_n = r_dir ? (r_line - 8'd1) : (r_line + 8'd1);
          if (r_left == 8'd1) w_state_n = S_DRAIN;
        end else begin
          w_col_n = r_col + COL_W'(1);
        end
      end
      S_DRAIN: begin
        w_line_n  = w_reg_bl0;
        w_col_n   = '0;
        w_left_n  = r_n;
        w_state_n = S_BLANK;
      end
      S_BLANK: begin
        if (r_col == COL_LAST) begin
          w_col_n  = '0;
          w_left_n = r_left - 8'd1;
          w_line_n = r_line + 8'd1;
          if (r_left == 8'd1) w_state_n = S_DONE;
        end else begin
          w_col_n = r_col + COL_W'(1);
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: ;
    endcase
    // w_start is only true in IDLE or DONE, so it overrides safely
    if (w_start) begin
      w_dir_n = w_s_dir;
      w_n_n   = w_n;
      w_top_n = w_s_top;
      w_bot_n = w_s_bot;
      w_col_n = '0;
      if (w_noop) begin
        w_state_n = S_DONE;
      end else if (w_copy != 8'd0) begin
        w_state_n = S_COPY;
        // up walks ascending from top, down descending from bottom,
        // so every source is read before it is overwritten
        w_line_n  = w_s_dir ? w_s_bot : w_s_top;
        w_left_n  = w_copy;
      end else begin
        w_state_n = S_BLANK;
        w_line_n  = w_s_bl0;
        w_left_n  = w_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_n      <= '0;
      r_top    <= '0;
      r_bottom <= '0;
      r_line   <= '0;
      r_col    <= '0;
      r_left   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_dir    <= w_dir_n;
      r_n      <= w_n_n;
      r_top    <= w_top_n;
      r_bottom <= w_bot_n;
      r_line   <= w_line_n;
      r_col    <= w_col_n;
      r_left   <= w_left_n;
    end
  end

  // copy-write pipeline and pending slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cw_vld    <= 1'b0;
      r_cw_addr   <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_dir  <= 1'b0;
      r_pend_step <= '0;
      r_pend_top  <= '0;
      r_pend_bot  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_cw_vld  <= (r_state == S_COPY);
      r_cw_addr <= (r_state == S_COPY) ? w_dst_addr : '0;
      if (w_from_pend) begin
        r_pend_vld <= 1'b0;
      end else if (i_req_valid && (r_state != S_IDLE) &&
                   (r_state != S_DONE) && !r_pend_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_dir  <= i_req_dir;
        r_pend_step <= i_req_step;
        r_pend_top  <= i_req_top;
        r_pend_bot  <= i_req_bottom;
      end
      // a DONE-cycle request with an empty slot starts directly instead
      if (i_req_valid && (r_state != S_IDLE) && r_pend_vld)
        r_overflow <= 1'b1;
    end
  end

  assign w_in_blank = (r_state == S_BLANK);

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_overflow = r_overflow;
  assign o_rd_en    = (r_state == S_COPY);
  assign o_rd_addr  = o_rd_en ? w_src_addr : '0;
  // copy writes never overlap blank writes: DRAIN separates them
  assign o_wr_en    = r_cw_vld | w_in_blank;
  assign o_wr_addr  = r_cw_vld ? r_cw_addr :
                      (w_in_blank ? w_dst_addr : '0);
  assign o_wr_data  = r_cw_vld ? i_rd_data :
                      (w_in_blank ? BLANK : '0);

endmodule

// File: tb/tb_scroll_engine.sv
// Bench for scroll_engine: a RAM model, a cycle monitor and a line-level
// reference model of the scroll operation.
module tb_scroll_engine;
  localparam int COLUMNS = 80;
  localparam int LINES   = 25;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int CELLS   = LINES * COLUMNS;
  localparam logic [DATA_W-1:0] BLANK = '0;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_dir;
  logic [7:0] req_step, req_top, req_bottom;
  logic busy, done, overflow, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data, wr_data;

  always #5 clk = ~clk;

  scroll_engine #(.COLUMNS(COLUMNS), .LINES(LINES), .ADDR_W(ADDR_W),
                  .DATA_W(DATA_W), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_dir(req_dir), .i_req_step(req_step),
    .i_req_top(req_top), .i_req_bottom(req_bottom),
    .o_busy(busy), .o_done(done), .o_overflow(overflow),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
  );

  // RAM: one-cycle read latency
  logic [DATA_W-1:0] mem   [0:CELLS-1];
  logic [DATA_W-1:0] ref_m [0:CELLS-1];
  initial rd_data = '0;
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  int n_tests = 0, n_fail = 0;

  // monitor, sampled on the falling edge
  int mon_cyc, cnt_busy, cnt_rd, cnt_wr, cnt_done, oob, conflict;
  int first_rd, first_wr, last_done, mon_top, mon_bot;
  always @(negedge clk) begin
    mon_cyc++;
    if (busy) cnt_busy++;
    if (rd_en) begin
      cnt_rd++;
      if (first_rd < 0) first_rd = mon_cyc;
      if (int'(rd_addr) / COLUMNS < mon_top || int'(rd_addr) / COLUMNS > mon_bot) oob++;
    end
    if (wr_en) begin
      cnt_wr++;
      if (first_wr < 0) first_wr = mon_cyc;
      if (int'(wr_addr) / COLUMNS < mon_top || int'(wr_addr) / COLUMNS > mon_bot) oob++;
    end
    if (rd_en && wr_en && rd_addr == wr_addr) conflict++;
    if (done) begin cnt_done++; last_done = mon_cyc; end
  end

  task automatic clr_mon(input int top, input int bot);
    mon_cyc = 0; cnt_busy = 0; cnt_rd = 0; cnt_wr = 0; cnt_done = 0;
    oob = 0; conflict = 0; first_rd = -1; first_wr = -1; last_done = -1;
    mon_top = top; mon_bot = bot;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_noop(int step, int top, int bot);
    return (step == 0) || (top > bot) || (bot >= LINES);
  endfunction

  // Reference: each line in the range takes the line n away, or BLANK
  // when that source falls outside the range.
  function automatic void ref_scroll(bit dir, int step, int top, int bot);
    logic [DATA_W-1:0] old [0:CELLS-1];
    int r, n, src;
    if (is_noop(step, top, bot)) return;
    old = ref_m;
    r = bot - top + 1;
    n = (step < r) ? step : r;
    for (int l = top; l <= bot; l++) begin
      src = dir ? l - n : l + n;
      for (int c = 0; c < COLUMNS; c++)
        ref_m[l*COLUMNS + c] = (src >= top && src <= bot) ? old[src*COLUMNS + c] : BLANK;
    end
  endfunction

  function automatic int exp_busy(int step, int top, int bot);
    int r, n;
    if (is_noop(step, top, bot)) return 1;
    r = bot - top + 1;
    n = (step < r) ? step : r;
    return (r - n) * COLUMNS + ((r > n) ? 1 : 0) + n * COLUMNS + 1;
  endfunction

  function automatic int exp_copy_cells(int step, int top, int bot);
    int r, n;
    if (is_noop(step, top, bot)) return 0;
    r = bot - top + 1;
    n = (step < r) ? step : r;
    return (r - n) * COLUMNS;
  endfunction

  task automatic check_screen(input string tag);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== ref_m[i]) bad++;
    check({tag, " screen"}, bad, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < CELLS; i++) mem[i] = $urandom;
    ref_m = mem;
  endtask

  task automatic drive(input bit dir, input int step, input int top, input int bot);
    req_dir = dir; req_step = 8'(step); req_top = 8'(top); req_bottom = 8'(bot);
    req_valid = 1'b1;
  endtask

  task automatic wait_done(input int want);
    for (int i = 0; i < 5000 && cnt_done < want; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic run_req(input string tag, input bit dir, input int step,
                         input int top, input int bot);
    int cc;
    @(negedge clk); #1;
    clr_mon(top, bot);
    drive(dir, step, top, bot);
    @(negedge clk); #1;
    req_valid = 1'b0;
    wait_done(1);
    @(negedge clk); #1;
    ref_scroll(dir, step, top, bot);
    cc = exp_copy_cells(step, top, bot);
    check({tag, " done"}, cnt_done, 1);
    check({tag, " busy cycles"}, cnt_busy, exp_busy(step, top, bot));
    check({tag, " done cycle"}, last_done, exp_busy(step, top, bot));
    check({tag, " rd count"}, cnt_rd, cc);
    check({tag, " wr count"}, cnt_wr,
          is_noop(step, top, bot) ? 0 : (bot - top + 1) * COLUMNS);
    check({tag, " out of range"}, oob, 0);
    check({tag, " rd/wr clash"}, conflict, 0);
    check({tag, " idle after"}, busy, 0);
    if (cc > 0) begin
      check({tag, " first rd"}, first_rd, 1);
      check({tag, " first wr"}, first_wr, 2);
    end
    check_screen(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
  endtask

  initial begin
    int sa, sb, ta, tb_, ba, bb, ea, eb;
    bit da, db;
    rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0;
    req_step = '0; req_top = '0; req_bottom = '0;
    clr_mon(0, LINES - 1);
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1 check_all_zero("post reset");

    // full-screen up by one, line i holds i
    for (int l = 0; l < LINES; l++)
      for (int c = 0; c < COLUMNS; c++) mem[l*COLUMNS + c] = DATA_W'(l);
    ref_m = mem;
    run_req("full up", 1'b0, 1, 0, 24);
    check("full up busy 2002", cnt_busy, 2002);

    fill_random();
    run_req("down 2 5..10", 1'b1, 2, 5, 10);
    run_req("step 30 3..7", 1'b0, 30, 3, 7);
    check("step 30 busy 401", cnt_busy, 401);
    run_req("noop step0", 1'b0, 0, 2, 9);
    run_req("noop top>bot", 1'b1, 3, 9, 4);
    run_req("noop bot25", 1'b0, 1, 3, 25);

    // three back-to-back requests: run, queue, drop
    fill_random();
    da = $urandom_range(0, 1); sa = $urandom_range(1, 6);
    ta = $urandom_range(0, 10); ba = ta + $urandom_range(0, 8);
    db = $urandom_range(0, 1); sb = $urandom_range(1, 6);
    tb_ = $urandom_range(5, 15); bb = tb_ + $urandom_range(0, 9);
    ea = exp_busy(sa, ta, ba); eb = exp_busy(sb, tb_, bb);
    @(negedge clk); #1;
    clr_mon(0, LINES - 1);
    drive(da, sa, ta, ba);
    @(negedge clk); #1 drive(db, sb, tb_, bb);
    @(negedge clk); #1 drive(1'b0, 1, 0, 24);
    @(negedge clk); #1 req_valid = 1'b0;
    wait_done(2);
    repeat (3) @(negedge clk);
    #1;
    ref_scroll(da, sa, ta, ba);
    ref_scroll(db, sb, tb_, bb);
    check("pend done count", cnt_done, 2);
    check("pend last done", last_done, ea + eb);
    check("pend busy unbroken", cnt_busy, ea + eb);
    check("pend overflow", overflow, 1);
    check("pend third dropped", busy, 0);
    check_screen("pend");

    fill_random();
    run_req("after drop", 1'b1, 1, 0, 24);
    check("overflow sticky", overflow, 1);

    // reset 100 cycles into a copy
    fill_random();
    @(negedge clk); #1;
    clr_mon(0, LINES - 1);
    drive(1'b0, 1, 0, 24);
    @(negedge clk); #1 req_valid = 1'b0;
    repeat (99) @(negedge clk);
    #1;
    check("pre-abort busy", busy, 1);
    rst = 1'b1;
    @(negedge clk); #1 check_all_zero("abort");
    rst = 1'b0;
    ref_m = mem;
    run_req("after abort", 1'b1, 3, 4, 20);

    // random requests, mostly valid, some no-ops
    for (int t = 0; t < 6; t++) begin
      int s, tp, bt;
      fill_random();
      s  = $urandom_range(0, 30);
      tp = $urandom_range(0, 24);
      bt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 26)
                                       : tp + $urandom_range(0, 24 - tp);
      run_req($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), s, tp, bt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
